// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes enter a small FIFO over valid/ready
// and are serialised LSB first at CLOCK_RATE/BAUD_RATE clocks per bit.
module uart_tx_buffered #(
  parameter int CLOCK_RATE = 10000000,
  parameter int BAUD_RATE  = 625000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [BW-1:0]   baud_cnt_reg, baud_cnt_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            tx_reg, tx_next;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            push, pop, fifo_empty, bit_done;
  logic [7:0]      head;

  // Ready depends only on the registered count, so a same-cycle pop never frees a slot early.
  assign tx_ready   = (count_reg < DEPTH_C);
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (count_reg == '0);
  assign head       = mem[rd_ptr_reg];
  assign bit_done   = (baud_cnt_reg == BAUD_LAST);

  assign tx         = tx_reg;
  assign busy       = (state_reg != IDLE) || !fifo_empty;
  assign fifo_count = count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= tx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        baud_cnt_next = '0;
        bit_idx_next  = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = head;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          shift_next    = {1'b0, shift_reg[7:1]};
          bit_idx_next  = bit_idx_reg + 1'b1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = head;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    case (state_reg)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule
